// File: rtl/uart_rx_port_if.sv
// Core-facing side of the UART receive port: pop strobe, {valid,data}
// head byte and the error/status flags. master = core, slave = receiver.
interface uart_rx_port_if;
    logic       rd_en;
    logic [8:0] uart_in;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    modport master (
        output rd_en,
        input  uart_in,
        input  frame_err,
        input  parity_err,
        input  overrun
    );

    modport slave (
        input  rd_en,
        output uart_in,
        output frame_err,
        output parity_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx_port.sv
// UART receiver: 2-flop synchronised rx, 8-bit frame FSM, FWFT byte FIFO.
// Ports: clock, reset_n (sync, active-low), rx (async serial in),
//   bus (uart_rx_port_if.slave: rd_en, uart_in, frame_err, parity_err,
//   overrun). Optional even parity bit: define UART_RX_PARITY_EN.
module uart_rx_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           rx,
    uart_rx_port_if.slave  bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t state, state_n;

    logic          rx_q1, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cnt_clr, do_shift, push, fe;
    logic          frame_err_q;

`ifdef UART_RX_PARITY_EN
    logic par_bit, do_par, pe, parity_err_q, par_bad;
    // Even parity: data plus parity bit must hold an even number of ones.
    assign par_bad = ^{shreg, par_bit};
`endif

    // ---------------- frame FSM ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        do_shift = 1'b0;
        push     = 1'b0;
        fe       = 1'b0;
`ifdef UART_RX_PARITY_EN
        do_par   = 1'b0;
        pe       = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Mid start bit: a high here means the low was a glitch.
                if (cnt == HALF_M1) begin
                    cnt_clr = 1'b1;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_clr  = 1'b1;
                    do_shift = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_M1) begin
                    cnt_clr = 1'b1;
                    do_par  = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_clr = 1'b1;
                    fe      = !rx_s;
`ifdef UART_RX_PARITY_EN
                    pe      = par_bad;
                    push    = rx_s && !par_bad;
`else
                    push    = rx_s;
`endif
                    // A low stop bit may be a break; wait for idle.
                    state_n = rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- receive datapath ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_q1       <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_q1       <= rx;
            rx_s        <= rx_q1;
            cnt         <= cnt_clr ? '0 : cnt + CW'(1);
            frame_err_q <= fe;
            if (state == IDLE)  bit_idx <= '0;
            else if (do_shift)  bit_idx <= bit_idx + 3'd1;
            // LSB arrives first, so shift in from the top.
            if (do_shift) shreg <= {rx_s, shreg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= pe;
            if (do_par) par_bit <= rx_s;
        end
    end
`endif

    // ---------------- receive FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, pop, accept, drop, overrun_q;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH);
    assign pop    = bus.rd_en && !empty;
    // A same-cycle pop frees the slot for a push into a full FIFO.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(accept) - (AW + 1)'(pop);
            if (drop)     overrun_q <= 1'b1;
            else if (pop) overrun_q <= 1'b0;
        end
    end

    assign bus.uart_in   = empty ? 9'h000 : {1'b1, mem[rd_ptr]};
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Frames are driven on rx at falling edges; outputs sampled there too.
module tb_uart_rx_port;

`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    int   n_tot = 0;
    int   n_bad = 0;
    int   fe_cnt = 0;
    int   pe_cnt = 0;

    uart_rx_port_if u_if();

    uart_rx_port #(
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .rx      (rx),
        .bus     (u_if.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.frame_err)  fe_cnt++;
        if (u_if.parity_err) pe_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Frame bits in send order, bit 0 = start bit.
    function automatic logic [10:0] mk(input logic [7:0] d,
                                       input logic stop_b);
`ifdef UART_RX_PARITY_EN
        return {stop_b, ^d, d, 1'b0};
`else
        return {1'b0, stop_b, d, 1'b0};
`endif
    endfunction

    task automatic send(input logic [10:0] bits);
        for (int i = 0; i < NB; i++) begin
            rx = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic rd(input string tag, input logic [8:0] exp);
        chk(tag, u_if.uart_in, exp);
        u_if.rd_en = 1'b1;
        @(negedge clk);
        u_if.rd_en = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!u_if.uart_in[8] && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("valid_in_time", u_if.uart_in[8], 1);
    endtask

    initial begin
        int f0;
        rx = 1'b1;
        u_if.rd_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_uart_in", u_if.uart_in, 9'h000);
        chk("rst_frame", u_if.frame_err, 0);
        chk("rst_parity", u_if.parity_err, 0);
        chk("rst_overrun", u_if.overrun, 0);

        // Single byte, latency bound then pop.
        send(mk(8'h41, 1'b1));
        wait_valid(3 + (NB - 10) * 16);
        chk("t1_data", u_if.uart_in, 9'h141);
        rd("t1_pop", 9'h141);
        chk("t1_empty", u_if.uart_in, 9'h000);
        repeat (20) @(negedge clk);

        // Short low glitch in idle.
        f0 = fe_cnt;
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("t2_empty", u_if.uart_in, 9'h000);
        chk("t2_no_fe", fe_cnt - f0, 0);

        // Bad stop bit followed by a held break.
        f0 = fe_cnt;
        send(mk(8'h55, 1'b0));
        repeat (40) @(negedge clk);
        chk("t3_break_empty", u_if.uart_in, 9'h000);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("t3_fe_once", fe_cnt - f0, 1);
        chk("t3_empty", u_if.uart_in, 9'h000);
        chk("t3_no_ovr", u_if.overrun, 0);

        // Five bytes, no reads: fifth dropped.
        for (int i = 1; i <= 5; i++) send(mk(8'(i), 1'b1));
        repeat (5) @(negedge clk);
        chk("t4_head", u_if.uart_in, 9'h101);
        chk("t4_ovr", u_if.overrun, 1);
        rd("t4_r1", 9'h101);
        chk("t4_ovr_clr", u_if.overrun, 0);
        rd("t4_r2", 9'h102);
        rd("t4_r3", 9'h103);
        rd("t4_r4", 9'h104);
        chk("t4_empty", u_if.uart_in, 9'h000);
        repeat (20) @(negedge clk);

        // Pop on the same edge as a push into a full FIFO.
        for (int i = 1; i <= 4; i++) send(mk(8'(i), 1'b1));
        fork
            send(mk(8'h05, 1'b1));
            begin
                repeat ((NB - 1) * 16 + 10) @(negedge clk);
                u_if.rd_en = 1'b1;
                @(negedge clk);
                u_if.rd_en = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        chk("t5_no_ovr", u_if.overrun, 0);
        rd("t5_r2", 9'h102);
        rd("t5_r3", 9'h103);
        rd("t5_r4", 9'h104);
        rd("t5_r5", 9'h105);
        chk("t5_empty", u_if.uart_in, 9'h000);
        repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        f0 = pe_cnt;
        send({1'b1, 1'b1, 8'h07, 1'b0});
        wait_valid(3);
        chk("t6_good", u_if.uart_in, 9'h107);
        chk("t6_no_pe", pe_cnt - f0, 0);
        rd("t6_pop", 9'h107);
        send({1'b1, 1'b0, 8'h07, 1'b0});
        repeat (20) @(negedge clk);
        chk("t6_pe_once", pe_cnt - f0, 1);
        chk("t6_no_push", u_if.uart_in, 9'h000);
`else
        chk("no_parity_err", pe_cnt, 0);
`endif

        // Reset in the middle of a frame abandons it.
        rx = 1'b0;
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("midrst_empty", u_if.uart_in, 9'h000);
        chk("midrst_ovr", u_if.overrun, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
